// File: rtl/dti_rr_arbiter_if.sv
// Handshake bundle between N DTI producers and the single tagged DTI output channel.
// Latency: none, wires only.
// Backpressure: din_ready per producer, dout_ready from the single consumer.
interface dti_rr_arbiter_if #(
    parameter int N    = 2,
    parameter int DIN  = 16,
    parameter int IDXW = (N > 1) ? $clog2(N) : 1
);
    logic [N*DIN-1:0]     din_data;
    logic [N-1:0]         din_valid;
    logic [N-1:0]         din_ready;
    logic [IDXW+DIN-1:0]  dout_data;
    logic                 dout_valid;
    logic                 dout_ready;

    // Producer/consumer side of the arbiter
    modport master (
        output din_data,
        output din_valid,
        input  din_ready,
        input  dout_data,
        input  dout_valid,
        output dout_ready
    );

    // Arbiter side
    modport slave (
        input  din_data,
        input  din_valid,
        output din_ready,
        output dout_data,
        output dout_valid,
        input  dout_ready
    );
endinterface

// File: rtl/dti_rr_arbiter.sv
// Round-robin arbiter sharing one registered DTI output between N producers; each beat tagged with its input index.
// Latency: 1 cycle from input transfer to dout_valid; one beat per cycle while dout_ready stays high.
// Backpressure: only the granted input sees din_ready, and only when the output register can load; eot locking optional.
module dti_rr_arbiter #(
    parameter int N        = 2,
    parameter int DIN      = 16,
    parameter bit LOCK_EOT = 1'b1,
    parameter int IDXW     = (N > 1) ? $clog2(N) : 1
) (
    input logic             clk,
    input logic             rst,
    dti_rr_arbiter_if.slave bus
);

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [IDXW-1:0]     ptr;
    logic [IDXW-1:0]     ptr_nxt;
    logic [IDXW-1:0]     lock_idx;
    logic [IDXW-1:0]     lock_idx_nxt;

    logic                load;
    logic                xfer;
    logic                eot;
    logic                grant_vld;
    logic [IDXW-1:0]     grant_idx;
    logic [DIN-1:0]      grant_dat;
    logic [N-1:0]        din_rdy;

    logic                out_vld;
    logic [IDXW+DIN-1:0] out_dat;

    // Index arithmetic modulo N; base and off are both below N so one wrap suffices
    function automatic logic [IDXW-1:0] next_idx(input logic [IDXW-1:0] base, input int unsigned off);
        int unsigned sum;
        sum = 32'(base) + off;
        if (sum >= unsigned'(N)) begin
            sum = sum - unsigned'(N);
        end
        return IDXW'(sum);
    endfunction

    // The output register accepts a new beat when empty or when its current beat leaves
    assign load = ~out_vld | bus.dout_ready;
    assign xfer = load & grant_vld;
    assign eot  = grant_dat[DIN-1];

    // Grant selection: the locked input only, or the first valid input at or after ptr
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        if (state == LOCKED) begin
            if (bus.din_valid[lock_idx]) begin
                grant_vld = 1'b1;
                grant_idx = lock_idx;
            end
        end else begin
            // Walk from farthest to nearest so the nearest valid candidate wins
            for (int k = N - 1; k >= 0; k--) begin
                if (bus.din_valid[next_idx(ptr, unsigned'(k))]) begin
                    grant_vld = 1'b1;
                    grant_idx = next_idx(ptr, unsigned'(k));
                end
            end
        end
    end

    // Data mux for the granted input
    always_comb begin
        grant_dat = '0;
        for (int i = 0; i < N; i++) begin
            if (grant_idx == IDXW'(i)) begin
                grant_dat = bus.din_data[i*DIN +: DIN];
            end
        end
    end

    // One-hot ready toward the winner; held low while reset is asserted
    always_comb begin
        din_rdy = '0;
        for (int i = 0; i < N; i++) begin
            din_rdy[i] = xfer & rst & (grant_idx == IDXW'(i));
        end
    end

    assign bus.din_ready  = din_rdy;
    assign bus.dout_valid = out_vld;
    assign bus.dout_data  = out_dat;

    // Lock and pointer evolution; only an actual input transfer moves them
    always_comb begin
        state_nxt    = state;
        ptr_nxt      = ptr;
        lock_idx_nxt = lock_idx;
        if (xfer) begin
            if (LOCK_EOT && !eot) begin
                state_nxt    = LOCKED;
                lock_idx_nxt = grant_idx;
            end else begin
                state_nxt = UNLOCKED;
                ptr_nxt   = next_idx(grant_idx, 1);
            end
        end
    end

    // Arbitration state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= UNLOCKED;
            ptr      <= '0;
            lock_idx <= '0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            lock_idx <= lock_idx_nxt;
        end
    end

    // Single-entry output register; data only changes when a new beat is captured
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_vld <= 1'b0;
            out_dat <= '0;
        end else if (load) begin
            out_vld <= grant_vld;
            if (grant_vld) begin
                out_dat <= {grant_idx, grant_dat};
            end
        end
    end

endmodule

// File: doc/dti_rr_arbiter.md
Name: dti_rr_arbiter

Overview:
- Round-robin arbiter that shares one registered DTI output channel between N DTI producers.
- Typical use: funnelling several streams into a single decoupler or shared datapath stage.
- Each output beat carries the winning input index, so downstream logic can demultiplex.
- Optional packet locking on an end-of-transaction (eot) bit keeps multi-beat transactions contiguous.

Parameters:
- N, 2, number of requesting inputs (1..16).
- DIN, 16, data width per input, including the eot bit when LOCK_EOT=1.
- LOCK_EOT, 1, if 1, din data bit DIN-1 is eot and the grant is held until the eot beat is transferred; if 0, every beat is arbitrated independently.
- IDXW, max(1,$clog2(N)), derived; width of the index field.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, asynchronous, active-low.
- din_data  input  N*DIN  input i data occupies bits [i*DIN +: DIN].
- din_valid  input  N  per-input valid.
- din_ready  output  N  per-input ready.
- dout_data  output  IDXW+DIN  {index, data}; index in the MSBs.
- dout_valid  output  1  output valid.
- dout_ready  input  1  output ready.

Behaviour:
- Reset (rst=0, asynchronous):
  - dout_valid=0, dout_data=0.
  - Priority pointer ptr=0.
  - State=UNLOCKED, lock_idx=0.
  - din_ready=0 while reset is asserted.
- DTI rules:
  - A transfer occurs on a cycle where valid&ready.
  - Producers hold valid and data stable until their transfer.
  - The block never drops dout_valid before a dout transfer.
- Output register (one entry):
  - load = ~dout_valid | dout_ready.
  - On load with a granted input g: dout_data <= {g, din_data[g]} and dout_valid <= 1.
  - On load with no grant: dout_valid <= 0.
  - Full throughput: one beat per cycle when dout_ready is held high.
  - Latency: input transfer to dout_valid is 1 cycle.
- Grant (combinational):
  - UNLOCKED: g = first i with din_valid[i]=1, searching from ptr upward with wrap N-1 -> 0. No grant if no input is valid.
  - LOCKED: g = lock_idx if din_valid[lock_idx]=1, else no grant. Other inputs are ignored even when valid.
  - din_ready[i] = load & grant_valid & (g==i). At most one din_ready bit is high per cycle.
  - While load=0 the grant may move to a newly arrived higher-priority input. No transfer occurs, so this is legal.
- State and pointer update, on a transfer from input g only:
  - LOCK_EOT=0: ptr <= (g+1) mod N. State stays UNLOCKED.
  - LOCK_EOT=1, eot=0: state <= LOCKED, lock_idx <= g. ptr is unchanged.
  - LOCK_EOT=1, eot=1: state <= UNLOCKED, ptr <= (g+1) mod N. This applies whether the block was UNLOCKED (single-beat packet) or LOCKED.
  - No transfer: state, ptr and lock_idx are held.
- Wrap: ptr advancing from N-1 goes to 0. The index field equals g exactly, zero-extended to IDXW.
- N=1: input 0 is always granted when valid. Index field is 1'b0. LOCKED state has no observable effect.
- Simultaneous events in one cycle: a dout transfer and a new din load happen together; dout_data is replaced and dout_valid stays 1.
- Reset mid-packet: lock is cleared, the buffered beat is discarded, ptr returns to 0. No partial-packet recovery.

Test Plan:
- Reset check: hold rst=0 with all din_valid=1 -> dout_valid=0 and din_ready=0; after release with dout_ready=1, the first accepted input is 0 and dout_data index=0.
- Fairness: N=4, LOCK_EOT=0, all valid continuously, dout_ready=1 -> index sequence 0,1,2,3,0,1..., one beat per cycle, and each input's data is seen in order.
- Backpressure: dout_ready=0 for 5 cycles with inputs 1 and 2 valid -> one beat is held (index=1), dout_data stable, din_ready=0; on release, beats index 1 then 2 with no loss or duplication.
- Locking: N=2, LOCK_EOT=1; input 0 sends a 3-beat packet (eot only on beat 3) while input 1 is continuously valid -> output order 0,0,0,1, and input 1 is never interleaved.
- Wrap and sparse valid: N=3, ptr=2 after input 1 wins; only input 0 valid -> grant 0 and ptr becomes 1.
- Async reset mid-packet: assert rst between beats 1 and 2 of a locked packet -> dout_valid falls immediately; after release, input 1 can win on the first arbitration.
